// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the memory arbiter's state/op encodings.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  // Latched description of the access currently owning the RAM
  typedef struct packed {
    logic dataSide;
    logic write;
  } arb_op_t;

endpackage

// File: rtl/memory_arbiter_access_timer.sv
// Wait-cycle counter for one RAM access; flags expiry on the cycle the count reaches TIMEOUT-1.
module access_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired_c = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data requests onto one variable-latency RAM port,
// returning single-cycle hits with load data, a per-access timeout and a sticky bus error.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned      ADDR_W   = 32,
  parameter int unsigned      DATA_W   = 32,
  parameter int unsigned      TIMEOUT  = 64,
  parameter logic [DATA_W-1:0] ERR_WORD = DATA_W'(32'hBAD1_BAD1)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              bus_err
);

  arb_state_t        state, stateNext;
  arb_op_t           op, opNext;
  logic              lastD, lastDNext;
  logic [ADDR_W-1:0] addrNext;
  logic [DATA_W-1:0] storeNext;
  logic [DATA_W-1:0] iloadNext, dloadNext;
  logic              renNext, wenNext;
  logic              ihitNext, dhitNext;
  logic              busErrNext;
  logic              timerClr, timerEn;
  logic              expired_c;
  logic              dReq;
  logic              done;
  logic [DATA_W-1:0] doneWord;

  access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK       (CLK),
    .nRST      (nRST),
    .clear     (timerClr),
    .enable    (timerEn),
    .expired_c (expired_c)
  );

  assign dReq     = dREN | dWEN;
  assign done     = ram_ready | expired_c;
  assign doneWord = ram_ready ? ramload : ERR_WORD;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and next-value logic for every registered output
  always_comb begin
    stateNext  = state;
    opNext     = op;
    lastDNext  = lastD;
    addrNext   = ramaddr;
    storeNext  = ramstore;
    iloadNext  = iload;
    dloadNext  = dload;
    renNext    = 1'b0;
    wenNext    = 1'b0;
    ihitNext   = 1'b0;
    dhitNext   = 1'b0;
    busErrNext = bus_err;
    timerClr   = 1'b0;
    timerEn    = 1'b0;

    case (state)
      IDLE: begin
        // Data wins unless it also won last time and fetch is waiting
        if (dReq && !(lastD && iREN)) begin
          stateNext = DACC;
          opNext    = '{dataSide: 1'b1, write: dWEN};
          lastDNext = 1'b1;
          addrNext  = daddr;
          storeNext = dstore;
          renNext   = !dWEN;
          wenNext   = dWEN;
          timerClr  = 1'b1;
        end else if (iREN) begin
          stateNext = IACC;
          opNext    = '{dataSide: 1'b0, write: 1'b0};
          lastDNext = 1'b0;
          addrNext  = iaddr;
          renNext   = 1'b1;
          timerClr  = 1'b1;
        end
      end

      IACC, DACC: begin
        timerEn = 1'b1;
        if (done) begin
          stateNext = RESP;
          ihitNext  = !op.dataSide;
          dhitNext  = op.dataSide;
          if (!ram_ready) begin
            busErrNext = 1'b1;
          end
          if (!op.write) begin
            if (op.dataSide) begin
              dloadNext = doneWord;
            end else begin
              iloadNext = doneWord;
            end
          end
        end else begin
          renNext = !op.write;
          wenNext = op.write;
        end
      end

      RESP: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op       <= '{dataSide: 1'b0, write: 1'b0};
      lastD    <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      op       <= opNext;
      lastD    <= lastDNext;
      ramaddr  <= addrNext;
      ramstore <= storeNext;
      iload    <= iloadNext;
      dload    <= dloadNext;
      ramREN   <= renNext;
      ramWEN   <= wenNext;
      ihit     <= ihitNext;
      dhit     <= dhitNext;
      bus_err  <= busErrNext;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a latency-programmable RAM responder plus a hit monitor.
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic        ram_ready;
  logic        bus_err;

  int cmpCnt = 0;
  int errCnt = 0;

  typedef struct {
    logic        dataSide;
    logic [31:0] load;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] expIload = 32'h0;
  logic [31:0] expDload = 32'h0;

  int          ramLat = 1;
  int          strobeCnt = 0;
  logic        respReady = 1'b0;
  logic        stray = 1'b0;
  logic [31:0] ramloadDrv = 32'h0;

  assign ram_ready = respReady | stray;
  assign ramload   = ramloadDrv;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h40) return 32'h2402000A;
    return {a[15:0], ~a[15:0]};
  endfunction

  // RAM model: answers on the ramLat-th strobe cycle; ramLat==0 never answers
  always @(negedge CLK) begin
    if (!nRST) begin
      strobeCnt = 0;
      respReady = 1'b0;
    end else if (ramREN || ramWEN) begin
      strobeCnt++;
      respReady  = (ramLat != 0) && (strobeCnt == ramLat);
      ramloadDrv = memData(ramaddr);
    end else begin
      strobeCnt = 0;
      respReady = 1'b0;
    end
  end

  // Every hit must match the oldest expected completion
  always @(negedge CLK) begin
    if (nRST && (ihit || dhit)) begin
      cmpCnt++;
      if (ihit && dhit) begin
        errCnt++;
        $display("FAIL hit_exclusive: ihit=%b dhit=%b both high", ihit, dhit);
      end else if (sb.size() == 0) begin
        errCnt++;
        $display("FAIL unexpected_hit: ihit=%b dhit=%b with nothing outstanding", ihit, dhit);
      end else begin
        e = sb.pop_front();
        if (dhit !== e.dataSide || (dhit ? dload : iload) !== e.load) begin
          errCnt++;
          $display("FAIL sb_hit: side=%b load=%h, expected side=%b load=%h",
                   dhit, dhit ? dload : iload, e.dataSide, e.load);
        end
      end
    end
  end

  task automatic run_access(input int limit, output int lat, output int ren, output int wen,
                            output logic [31:0] addr, output logic [31:0] store,
                            output logic side, output logic gotHit);
    lat = 0; ren = 0; wen = 0; addr = '0; store = '0; side = 1'b0; gotHit = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      lat++;
      if (ramREN) ren++;
      if (ramWEN) wen++;
      if (ramREN || ramWEN) begin
        addr  = ramaddr;
        store = ramstore;
      end
      if (ihit || dhit) begin
        gotHit = 1'b1;
        side   = dhit;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (2) @(negedge CLK);
    cmpCnt++;
    if ({ihit, dhit, ramREN, ramWEN, bus_err} !== 5'b0) begin
      errCnt++;
      $display("FAIL reset_ctrl: {ihit,dhit,ramREN,ramWEN,bus_err}=%b expected 00000",
               {ihit, dhit, ramREN, ramWEN, bus_err});
    end
    cmpCnt++;
    if ({iload, dload, ramaddr, ramstore} !== 128'h0) begin
      errCnt++;
      $display("FAIL reset_data: iload=%h dload=%h ramaddr=%h ramstore=%h expected all 0",
               iload, dload, ramaddr, ramstore);
    end
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    cmpCnt++;
    if ({ramREN, ramWEN, ihit, dhit} !== 4'b0) begin
      errCnt++;
      $display("FAIL idle_quiet: {ramREN,ramWEN,ihit,dhit}=%b expected 0000",
               {ramREN, ramWEN, ihit, dhit});
    end
  endtask

  task automatic test_instr_fetch();
    int lat, ren, wen; logic [31:0] a, s; logic side, got;
    ramLat = 1; iREN = 1; iaddr = 32'h40;
    expIload = 32'h2402000A;
    sb.push_back('{1'b0, expIload});
    run_access(10, lat, ren, wen, a, s, side, got);
    iREN = 0;
    cmpCnt++;
    if (got !== 1'b1 || side !== 1'b0 || lat != 2) begin
      errCnt++;
      $display("FAIL ifetch_hit: got=%b side=%b latency=%0d expected 1/0/2", got, side, lat);
    end
    cmpCnt++;
    if (ren != 1 || wen != 0 || a !== 32'h40) begin
      errCnt++;
      $display("FAIL ifetch_ram: ren=%0d wen=%0d addr=%h expected 1/0/00000040", ren, wen, a);
    end
    @(negedge CLK);
    cmpCnt++;
    if (ihit !== 1'b0 || iload !== expIload) begin
      errCnt++;
      $display("FAIL ifetch_pulse: ihit=%b iload=%h expected 0/%h", ihit, iload, expIload);
    end
  endtask

  task automatic test_priority();
    int lat, ren, wen; logic [31:0] a, s; logic side, got;
    ramLat = 1; iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h80;
    expDload = memData(32'h80);
    expIload = memData(32'h44);
    sb.push_back('{1'b1, expDload});
    sb.push_back('{1'b0, expIload});
    sb.push_back('{1'b1, expDload});
    run_access(10, lat, ren, wen, a, s, side, got);
    cmpCnt++;
    if (got !== 1'b1 || side !== 1'b1 || a !== 32'h80) begin
      errCnt++;
      $display("FAIL prio_first: got=%b side=%b addr=%h expected 1/1/00000080", got, side, a);
    end
    run_access(10, lat, ren, wen, a, s, side, got);
    iREN = 0;
    cmpCnt++;
    if (got !== 1'b1 || side !== 1'b0 || a !== 32'h44) begin
      errCnt++;
      $display("FAIL prio_alternate: got=%b side=%b addr=%h expected 1/0/00000044", got, side, a);
    end
    run_access(10, lat, ren, wen, a, s, side, got);
    dREN = 0;
    cmpCnt++;
    if (got !== 1'b1 || side !== 1'b1) begin
      errCnt++;
      $display("FAIL prio_third: got=%b side=%b expected 1/1", got, side);
    end
    @(negedge CLK);
  endtask

  task automatic test_write();
    int lat, ren, wen; logic [31:0] a, s; logic side, got;
    ramLat = 3; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    sb.push_back('{1'b1, expDload});
    run_access(20, lat, ren, wen, a, s, side, got);
    dWEN = 0;
    cmpCnt++;
    if (got !== 1'b1 || lat != 4 || wen != 3 || ren != 0) begin
      errCnt++;
      $display("FAIL write_strobe: got=%b latency=%0d wen=%0d ren=%0d expected 1/4/3/0",
               got, lat, wen, ren);
    end
    cmpCnt++;
    if (a !== 32'h100 || s !== 32'hDEADBEEF) begin
      errCnt++;
      $display("FAIL write_data: addr=%h store=%h expected 00000100/deadbeef", a, s);
    end
    @(negedge CLK);
    cmpCnt++;
    if (dhit !== 1'b0 || dload !== expDload) begin
      errCnt++;
      $display("FAIL write_pulse: dhit=%b dload=%h expected 0/%h", dhit, dload, expDload);
    end
    // Both enables: the write must win
    ramLat = 2; dREN = 1; dWEN = 1; daddr = 32'h104; dstore = 32'h12345678;
    sb.push_back('{1'b1, expDload});
    run_access(20, lat, ren, wen, a, s, side, got);
    dREN = 0; dWEN = 0;
    cmpCnt++;
    if (got !== 1'b1 || wen != 2 || ren != 0 || s !== 32'h12345678) begin
      errCnt++;
      $display("FAIL rw_both: got=%b wen=%0d ren=%0d store=%h expected 1/2/0/12345678",
               got, wen, ren, s);
    end
    @(negedge CLK);
  endtask

  task automatic test_timeout();
    int lat, ren, wen; logic [31:0] a, s; logic side, got;
    cmpCnt++;
    if (bus_err !== 1'b0) begin
      errCnt++;
      $display("FAIL buserr_pre: bus_err=%b expected 0", bus_err);
    end
    ramLat = 0; dREN = 1; daddr = 32'h200;
    expDload = 32'hBAD1BAD1;
    sb.push_back('{1'b1, expDload});
    run_access(100, lat, ren, wen, a, s, side, got);
    dREN = 0;
    cmpCnt++;
    if (got !== 1'b1 || lat != 65 || ren != 64) begin
      errCnt++;
      $display("FAIL timeout_latency: got=%b latency=%0d ren=%0d expected 1/65/64", got, lat, ren);
    end
    cmpCnt++;
    if (bus_err !== 1'b1) begin
      errCnt++;
      $display("FAIL timeout_buserr: bus_err=%b expected 1", bus_err);
    end
    @(negedge CLK);
    ramLat = 1; iREN = 1; iaddr = 32'h48;
    expIload = memData(32'h48);
    sb.push_back('{1'b0, expIload});
    run_access(10, lat, ren, wen, a, s, side, got);
    iREN = 0;
    cmpCnt++;
    if (got !== 1'b1 || lat != 2 || bus_err !== 1'b1) begin
      errCnt++;
      $display("FAIL buserr_sticky: got=%b latency=%0d bus_err=%b expected 1/2/1", got, lat, bus_err);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    logic act;
    ramLat = 0; dREN = 1; daddr = 32'h300;
    repeat (3) @(negedge CLK);
    cmpCnt++;
    if (ramREN !== 1'b1) begin
      errCnt++;
      $display("FAIL midreset_pre: ramREN=%b expected 1", ramREN);
    end
    nRST = 1'b0; dREN = 0;
    #1;
    cmpCnt++;
    if ({ramREN, ramWEN, bus_err, ihit, dhit} !== 5'b0) begin
      errCnt++;
      $display("FAIL midreset_async: {ramREN,ramWEN,bus_err,ihit,dhit}=%b expected 00000",
               {ramREN, ramWEN, bus_err, ihit, dhit});
    end
    expIload = 32'h0;
    expDload = 32'h0;
    @(negedge CLK);
    nRST = 1'b1;
    act = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (ramREN || ramWEN || ihit || dhit) act = 1'b1;
    end
    cmpCnt++;
    if (act !== 1'b0 || dload !== 32'h0) begin
      errCnt++;
      $display("FAIL midreset_after: activity=%b dload=%h expected 0/00000000", act, dload);
    end
  endtask

  task automatic test_stray();
    int lat, ren, wen; logic [31:0] a, s; logic side, got;
    logic act;
    act = 1'b0;
    stray = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (ramREN || ramWEN || ihit || dhit) act = 1'b1;
    end
    stray = 1'b0;
    cmpCnt++;
    if (act !== 1'b0 || iload !== expIload || dload !== expDload) begin
      errCnt++;
      $display("FAIL stray_idle: activity=%b iload=%h dload=%h expected 0/%h/%h",
               act, iload, dload, expIload, expDload);
    end
    ramLat = 1; iREN = 1; iaddr = 32'h4C;
    expIload = memData(32'h4C);
    sb.push_back('{1'b0, expIload});
    run_access(10, lat, ren, wen, a, s, side, got);
    iREN = 0;
    stray = 1'b1;
    @(negedge CLK);
    stray = 1'b0;
    act = (ihit || dhit || ramREN || ramWEN);
    @(negedge CLK);
    act = act | ihit | dhit | ramREN | ramWEN;
    cmpCnt++;
    if (got !== 1'b1 || act !== 1'b0 || iload !== expIload || dload !== expDload) begin
      errCnt++;
      $display("FAIL stray_resp: got=%b activity=%b iload=%h dload=%h expected 1/0/%h/%h",
               got, act, iload, dload, expIload, expDload);
    end
  endtask

  initial begin
    test_reset();
    test_instr_fetch();
    test_priority();
    test_write();
    test_timeout();
    test_reset_mid();
    test_stray();
    repeat (2) @(negedge CLK);
    cmpCnt++;
    if (sb.size() != 0) begin
      errCnt++;
      $display("FAIL sb_drain: %0d completions outstanding, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
